orb_wr_arbiter: RTL and testbench

//  Shares the single write port of the active orbit-frame RAM bank (ramM16) between N

---
 rtl/orb_wr_arbiter.sv | 158 +++++++++++++++
 tb/tb_orb_wr_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/orb_wr_arbiter.sv
// orb_wr_arbiter: two-tier round-robin owner of the orbit RAM write port.
// Drains packet FIFOs in bursts into per-source slots of the active bank.
module orb_wr_arbiter #(
    parameter int               N_REQ     = 4,
    parameter int               DW        = 12,
    parameter int               AW        = 11,
    parameter int               BURST     = 16,
    parameter int               MAX_WORDS = 64,
    parameter logic [N_REQ-1:0] FAST_MASK = 4'b0101
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                iSW,
    input  logic [N_REQ-1:0]    iEmpty,
    input  logic [N_REQ*DW-1:0] iData,
    input  logic [N_REQ*AW-1:0] iBase,
    output logic [N_REQ-1:0]    oRdReq,
    output logic                oWE,
    output logic [AW-1:0]       oWrAddr,
    output logic [DW-1:0]       oOrbWord,
    output logic [N_REQ-1:0]    oGrant,
    output logic                oBusy,
    output logic [N_REQ-1:0]    oOverrun
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(BURST + 1);
    localparam int OW = $clog2(MAX_WORDS + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] XFER  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]       state;
    logic [IW-1:0]    gIdx;
    logic [IW-1:0]    wrIdx;
    logic [CW-1:0]    cnt;
    logic [IW-1:0]    fastPtr;
    logic [IW-1:0]    slowPtr;
    logic [OW-1:0]    offset [N_REQ];
    logic             swD;
    logic             swEdge;

    logic [N_REQ-1:0] fastCand;
    logic [N_REQ-1:0] tierCand;
    logic [IW-1:0]    tierPtr;
    logic [IW-1:0]    pos;
    logic [IW-1:0]    pickIdx;
    logic [N_REQ-1:0] pickOh;
    logic             pickOk;

    logic             rdFire;
    logic             atCap;
    logic [IW-1:0]    nextIdx;
    logic [AW-1:0]    addr;

    assign swEdge = iSW ^ swD;
    assign oBusy  = (state != IDLE);

    assign atCap = (offset[gIdx] >= OW'(MAX_WORDS));
    assign rdFire = (state == XFER) && !iEmpty[gIdx]
                 && (cnt < CW'(BURST)) && !swEdge;
    assign oRdReq = rdFire ? oGrant : '0;

    assign nextIdx = (gIdx == IW'(N_REQ - 1)) ? '0 : gIdx + IW'(1);
    assign addr = iBase[gIdx*AW +: AW] + AW'(offset[gIdx]);

    // Data follows the FIFO q bus in the cycle after the read.
    assign oOrbWord = oWE ? iData[wrIdx*DW +: DW] : '0;

    // Tier select, then first candidate at or after the tier pointer.
    always_comb begin
        fastCand = ~iEmpty & FAST_MASK;
        tierCand = (|fastCand) ? fastCand : (~iEmpty & ~FAST_MASK);
        tierPtr  = (|fastCand) ? fastPtr : slowPtr;
        pickIdx  = '0;
        pickOk   = 1'b0;
        pos      = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            pos = IW'((int'(tierPtr) + k) % N_REQ);
            if (tierCand[pos]) begin
                pickIdx = pos;
                pickOk  = 1'b1;
            end
        end
        pickOh = '0;
        pickOh[pickIdx] = pickOk;
    end

    // Bank-select history; follows iSW through reset so release is edge-free.
    always_ff @(posedge clk) begin
        swD <= iSW;
    end

    // Grant FSM: arbitrate, burst, then one settle cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            oGrant  <= '0;
            gIdx    <= '0;
            cnt     <= '0;
            fastPtr <= '0;
            slowPtr <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pickOk) begin
                        gIdx   <= pickIdx;
                        oGrant <= pickOh;
                        cnt    <= '0;
                        state  <= XFER;
                    end
                end
                XFER: begin
                    if (rdFire) cnt <= cnt + CW'(1);
                    else        state <= DRAIN;
                end
                DRAIN: begin
                    if (FAST_MASK[gIdx]) fastPtr <= nextIdx;
                    else                 slowPtr <= nextIdx;
                    oGrant <= '0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Per-source frame offsets and overrun flags; a bank switch restarts them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_REQ; i++) offset[i] <= '0;
            oOverrun <= '0;
        end else if (swEdge) begin
            for (int i = 0; i < N_REQ; i++) offset[i] <= '0;
            oOverrun <= '0;
        end else if (rdFire) begin
            if (!atCap) offset[gIdx] <= offset[gIdx] + OW'(1);
            else        oOverrun[gIdx] <= 1'b1;
        end
    end

    // Write stage: address is fixed at read time, WE one cycle later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            oWE     <= 1'b0;
            oWrAddr <= '0;
            wrIdx   <= '0;
        end else begin
            oWE <= rdFire && !atCap;
            if (rdFire) begin
                oWrAddr <= addr;
                wrIdx   <= gIdx;
            end
        end
    end

endmodule

// File: tb/tb_orb_wr_arbiter.sv
// tb_orb_wr_arbiter: FIFO models feed the arbiter; expected RAM writes
// are queued per source at load time and popped on every WE.
`timescale 1ns/1ps
module tb_orb_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 12;
    localparam int AW = 11;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            iSW = 1'b0;
    logic [N-1:0]    iEmpty = '1;
    logic [N*DW-1:0] iData;
    logic [N*AW-1:0] iBase;
    logic [N-1:0]    oRdReq;
    logic            oWE;
    logic [AW-1:0]   oWrAddr;
    logic [DW-1:0]   oOrbWord;
    logic [N-1:0]    oGrant;
    logic            oBusy;
    logic [N-1:0]    oOverrun;

    logic [DW-1:0]    dataQ [N] = '{default: '0};
    logic [DW-1:0]    fq [N][$];
    logic [AW+DW-1:0] expQ [N][$];

    int grantLog[$];
    int burstLen[$];
    int rdCyc[$];
    int wrCyc[$];
    int rdCnt [N] = '{default: 0};
    int wrCnt [N] = '{default: 0};
    int t3Grant [6] = '{0, 2, 0, 2, 0, 2};
    int t3Len [6] = '{16, 16, 16, 16, 8, 8};

    int nChecks = 0;
    int nPass = 0;
    int cyc = 0;
    int lastBusy = 0;
    int seqNo = 0;
    logic [N-1:0] rdMask = '0;
    logic [N-1:0] prevGrant = '0;
    logic prevRd = 1'b0;

    assign iBase = {11'd700, 11'd500, 11'd300, 11'd100};
    assign iData = {dataQ[3], dataQ[2], dataQ[1], dataQ[0]};

    always #5 clk = ~clk;

    orb_wr_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .iSW      (iSW),
        .iEmpty   (iEmpty),
        .iData    (iData),
        .iBase    (iBase),
        .oRdReq   (oRdReq),
        .oWE      (oWE),
        .oWrAddr  (oWrAddr),
        .oOrbWord (oOrbWord),
        .oGrant   (oGrant),
        .oBusy    (oBusy),
        .oOverrun (oOverrun)
    );

    task automatic checkVal(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    function automatic int baseOf(input int r);
        return 100 + 200 * r;
    endfunction

    task automatic pushWord(input int r, input bit doExp, input int off);
        logic [DW-1:0] w;
        logic [31:0] rv;
        logic [31:0] sv;
        rv = r;
        sv = seqNo;
        w = {rv[1:0], sv[9:0]};
        seqNo++;
        fq[r].push_back(w);
        if (doExp) expQ[r].push_back({AW'(baseOf(r) + off), w});
    endtask

    task automatic loadRun(input int r, input int n, input int off0);
        for (int k = 0; k < n; k++)
            pushWord(r, (off0 + k) < 64, off0 + k);
    endtask

    task automatic newFrame();
        @(posedge clk);
        #1 iSW = ~iSW;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic waitIdle(input int limit);
        int n;
        int quiet;
        bit allEmpty;
        n = 0;
        quiet = 0;
        while (quiet < 3 && n < limit) begin
            @(negedge clk);
            n++;
            allEmpty = 1'b1;
            for (int i = 0; i < N; i++)
                if (fq[i].size() != 0) allEmpty = 1'b0;
            if (!oBusy && !oWE && allEmpty) quiet++;
            else quiet = 0;
        end
        if (quiet < 3) checkVal("idleTimeout", quiet, 3);
    endtask

    task automatic checkDrained(input string tag);
        int s;
        s = 0;
        for (int i = 0; i < N; i++) s += expQ[i].size();
        checkVal(tag, s, 0);
    endtask

    task automatic waitReads(input int r, input int want, input string tag);
        int n;
        int g;
        n = 0;
        g = 0;
        while (n < want && g < 200) begin
            @(negedge clk);
            g++;
            if (oRdReq[r]) n++;
        end
        if (n < want) checkVal(tag, n, want);
    endtask

    always @(posedge clk) cyc++;

    // FIFO models: pop on a sampled rdreq, q valid in the next cycle.
    always @(posedge clk) begin
        logic [N-1:0] m;
        m = rst ? rdMask : '0;
        #1;
        for (int i = 0; i < N; i++)
            if (m[i] && fq[i].size() > 0) dataQ[i] = fq[i].pop_front();
        #1;
        for (int i = 0; i < N; i++) iEmpty[i] = (fq[i].size() == 0);
    end

    // Monitor: read legality, grant log and scoreboard compare of writes.
    always @(negedge clk) begin
        int r;
        logic [AW+DW-1:0] e;
        rdMask = oRdReq;
        if (oBusy) lastBusy = cyc;
        if (oGrant != '0 && oGrant != prevGrant) begin
            for (int i = 0; i < N; i++)
                if (oGrant[i]) grantLog.push_back(i);
            burstLen.push_back(0);
        end
        if (oRdReq != '0) begin
            checkVal("rdOneHot", 32'($onehot(oRdReq)), 1);
            checkVal("rdInGrant", 32'(oRdReq & ~oGrant), 0);
            checkVal("rdNotEmpty", 32'(oRdReq & iEmpty), 0);
            for (int i = 0; i < N; i++)
                if (oRdReq[i]) rdCnt[i]++;
            if (burstLen.size() > 0)
                burstLen[burstLen.size()-1] = burstLen[burstLen.size()-1] + 1;
            rdCyc.push_back(cyc);
        end
        if (oWE) begin
            checkVal("wrLatency", 32'(prevRd), 1);
            r = (int'(oWrAddr) - 100) / 200;
            if (r < 0) r = 0;
            if (r > N - 1) r = N - 1;
            checkVal("wrExpected", 32'(expQ[r].size() != 0), 1);
            if (expQ[r].size() != 0) begin
                e = expQ[r].pop_front();
                checkVal("wrAddrData", 32'({oWrAddr, oOrbWord}), 32'(e));
            end
            wrCnt[r]++;
            wrCyc.push_back(cyc);
        end
        prevRd = |oRdReq;
        prevGrant = oGrant;
    end

    initial begin
        int g0;
        int r0;
        int w0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkVal("rstOut", 32'({oWE, oRdReq, oGrant, oBusy, oOverrun}), 0);
        checkVal("rstAddr", 32'({oWrAddr, oOrbWord}), 0);
        @(posedge clk);
        #1 rst = 1'b1;

        // T1: three words, back-to-back reads, writes one cycle later
        newFrame();
        rdCyc.delete();
        wrCyc.delete();
        loadRun(0, 3, 0);
        waitIdle(100);
        checkVal("t1Reads", rdCyc.size(), 3);
        checkVal("t1Writes", wrCyc.size(), 3);
        if (rdCyc.size() == 3 && wrCyc.size() == 3) begin
            checkVal("t1RdGap1", rdCyc[1] - rdCyc[0], 1);
            checkVal("t1RdGap2", rdCyc[2] - rdCyc[1], 1);
            for (int i = 0; i < 3; i++)
                checkVal("t1WrLat", wrCyc[i] - rdCyc[i], 1);
            checkVal("t1Drain", lastBusy - wrCyc[2], 1);
        end
        checkDrained("t1Left");

        // T2: fast tier wins over slow
        g0 = grantLog.size();
        @(posedge clk);
        #1;
        loadRun(1, 2, 0);
        loadRun(2, 2, 0);
        waitIdle(100);
        checkVal("t2Grants", grantLog.size() - g0, 2);
        if (grantLog.size() - g0 == 2) begin
            checkVal("t2First", grantLog[g0], 2);
            checkVal("t2Second", grantLog[g0+1], 1);
        end
        checkDrained("t2Left");

        // T3: round-robin 16-word bursts inside the fast tier
        newFrame();
        g0 = grantLog.size();
        loadRun(0, 40, 0);
        loadRun(2, 40, 0);
        waitIdle(400);
        checkVal("t3Grants", grantLog.size() - g0, 6);
        if (grantLog.size() - g0 == 6) begin
            for (int i = 0; i < 6; i++) begin
                checkVal("t3Order", grantLog[g0+i], t3Grant[i]);
                checkVal("t3Burst", burstLen[g0+i], t3Len[i]);
            end
        end
        checkDrained("t3Left");

        // T4: frame overflow drops excess words, bank switch clears it
        newFrame();
        r0 = rdCnt[3];
        w0 = wrCnt[3];
        loadRun(3, 70, 0);
        waitIdle(600);
        checkVal("t4Reads", rdCnt[3] - r0, 70);
        checkVal("t4Writes", wrCnt[3] - w0, 64);
        checkVal("t4Overrun", 32'(oOverrun), 32'h8);
        @(posedge clk);
        #1 iSW = ~iSW;
        repeat (2) @(posedge clk);
        #1;
        checkVal("t4OvrClear", 32'(oOverrun), 0);
        loadRun(3, 2, 0);
        waitIdle(100);
        checkDrained("t4Left");

        // T5: bank switch mid-burst ends it; next grant restarts at base
        newFrame();
        g0 = grantLog.size();
        for (int k = 0; k < 8; k++) pushWord(1, 1'b1, (k < 5) ? k : k - 5);
        waitReads(1, 5, "t5Wait");
        @(posedge clk);
        #1 iSW = ~iSW;
        waitIdle(200);
        checkVal("t5Grants", grantLog.size() - g0, 2);
        if (grantLog.size() - g0 == 2) begin
            checkVal("t5Burst0", burstLen[g0], 5);
            checkVal("t5Burst1", burstLen[g0+1], 3);
        end
        checkDrained("t5Left");

        // T6: reset mid-burst loses the in-flight word, restarts offsets
        newFrame();
        for (int k = 0; k < 10; k++)
            pushWord(2, k != 2, (k < 2) ? k : k - 3);
        waitReads(2, 3, "t6Wait");
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checkVal("t6RstOut", 32'({oWE, oRdReq, oGrant, oBusy}), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        waitIdle(200);
        checkDrained("t6Left");

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
